// File: rtl/mux2_rr_ctrl_pkg.sv
// Shared definitions for the mux2_rr_ctrl block: FSM encodings, select
// constants and default sizes.
package mux2_rr_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    HOLD  = 2'd2
  } state_t;

  localparam logic SEL_A = 1'b0;
  localparam logic SEL_B = 1'b1;

  localparam int WIDTH_DEF = 4;
  localparam int CNT_W     = 8;

endpackage

// File: rtl/mux2_rr_ctrl_rr_arb2.sv
// Two-requester round-robin arbiter. req[0] is source A, req[1] is source B.
// On a tie the source that was not granted last wins.
module rr_arb2
  import mux2_rr_ctrl_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last,
  output logic [1:0] gnt
);

  always_comb begin
    gnt = 2'b00;
    case (req)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      2'b11:   gnt = (last == SEL_A) ? 2'b10 : 2'b01;
      default: gnt = 2'b00;
    endcase
  end

endmodule

// File: rtl/mux2_rr_ctrl.sv
// Round-robin controller around an external 2:1 mux with active-low enable.
// Optional per-source grant counters when MUX2_RR_CTRL_GRANT_CNT_EN is defined.
//
// state | meaning
// IDLE  | arbitrate sources, load granted word into mux_a/mux_b
// DRIVE | mux enabled for one cycle, mux_y captured and compared at the edge
// HOLD  | captured word offered downstream until out_ready
module mux2_rr_ctrl
  import mux2_rr_ctrl_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             a_valid,
  input  logic [WIDTH-1:0] a_data,
  output logic             a_ready,
  input  logic             b_valid,
  input  logic [WIDTH-1:0] b_data,
  output logic             b_ready,
  output logic [WIDTH-1:0] mux_a,
  output logic [WIDTH-1:0] mux_b,
  output logic             mux_sel,
  output logic             mux_en_n,
  input  logic [WIDTH-1:0] mux_y,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  input  logic             out_ready,
`ifdef MUX2_RR_CTRL_GRANT_CNT_EN
  output logic [CNT_W-1:0] cnt_a,
  output logic [CNT_W-1:0] cnt_b,
`endif
  output logic             err
);

  state_t     state, state_nxt;
  logic       last;
  logic [1:0] gnt;

  rr_arb2 u_arb (
    .req  ({b_valid, a_valid}),
    .last (last),
    .gnt  (gnt)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (a_ready || b_ready) state_nxt = DRIVE;
      DRIVE:   state_nxt = HOLD;
      HOLD:    if (out_valid && out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Ready is gated by rst so no word is accepted while the block is held in reset.
  always_comb begin
    a_ready  = (state == IDLE) && !rst && gnt[0];
    b_ready  = (state == IDLE) && !rst && gnt[1];
    mux_en_n = (state != DRIVE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mux_a     <= '0;
      mux_b     <= '0;
      mux_sel   <= SEL_A;
      last      <= SEL_B;
      out_data  <= '0;
      out_valid <= 1'b0;
      err       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (a_ready) begin
            mux_a   <= a_data;
            mux_sel <= SEL_A;
            last    <= SEL_A;
          end else if (b_ready) begin
            mux_b   <= b_data;
            mux_sel <= SEL_B;
            last    <= SEL_B;
          end
        end
        DRIVE: begin
          out_data  <= mux_y;
          out_valid <= 1'b1;
          if (mux_y != ((mux_sel == SEL_B) ? mux_b : mux_a)) err <= 1'b1;
        end
        HOLD: begin
          if (out_ready) out_valid <= 1'b0;
        end
        default: ;
      endcase
    end
  end

`ifdef MUX2_RR_CTRL_GRANT_CNT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_a <= '0;
      cnt_b <= '0;
    end else begin
      if (a_ready && (cnt_a != {CNT_W{1'b1}})) cnt_a <= cnt_a + 1'b1;
      if (b_ready && (cnt_b != {CNT_W{1'b1}})) cnt_b <= cnt_b + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_mux2_rr_ctrl.sv
// Directed bench for mux2_rr_ctrl with a behavioural active-low-enable mux
// that can be forced to return 0000.
module tb_mux2_rr_ctrl;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic         a_valid, b_valid, out_ready;
  logic [W-1:0] a_data, b_data;
  logic         a_ready, b_ready, mux_sel, mux_en_n, out_valid, err;
  logic [W-1:0] mux_a, mux_b, mux_y, out_data;
  logic         fault;
`ifdef MUX2_RR_CTRL_GRANT_CNT_EN
  logic [7:0]   cnt_a, cnt_b;
`endif

  int n_checks = 0;
  int n_fails  = 0;

  always #5 clk = ~clk;

  assign mux_y = fault ? '0 : (mux_en_n ? '0 : (mux_sel ? mux_b : mux_a));

  mux2_rr_ctrl #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .a_valid   (a_valid),
    .a_data    (a_data),
    .a_ready   (a_ready),
    .b_valid   (b_valid),
    .b_data    (b_data),
    .b_ready   (b_ready),
    .mux_a     (mux_a),
    .mux_b     (mux_b),
    .mux_sel   (mux_sel),
    .mux_en_n  (mux_en_n),
    .mux_y     (mux_y),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ready (out_ready),
`ifdef MUX2_RR_CTRL_GRANT_CNT_EN
    .cnt_a     (cnt_a),
    .cnt_b     (cnt_b),
`endif
    .err       (err)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one clock and settle just after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; fault = 1'b0;
    a_valid = 1'b1; b_valid = 1'b0; a_data = 4'b1010; b_data = 4'b0000;
    out_ready = 1'b1;
    tick(); tick();

    // Reset state
    check("rst_a_ready", a_ready, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_mux_en_n", mux_en_n, 1);
    check("rst_mux_a", mux_a, 0);
    check("rst_mux_sel", mux_sel, 0);
    check("rst_err", err, 0);
    check("rst_out_data", out_data, 0);

    // A-only request
    rst = 1'b0; a_valid = 1'b1; a_data = 4'b1010;
    #1;
    check("aonly_a_ready", a_ready, 1);
    check("aonly_b_ready", b_ready, 0);
    tick(); a_valid = 1'b0; a_data = 4'b0000; #1;
    check("aonly_c1_sel", mux_sel, 0);
    check("aonly_c1_en_n", mux_en_n, 0);
    check("aonly_c1_mux_a", mux_a, 4'b1010);
    check("aonly_c1_out_valid", out_valid, 0);
    tick();
    check("aonly_c2_out_valid", out_valid, 1);
    check("aonly_c2_out_data", out_data, 4'b1010);
    check("aonly_c2_err", err, 0);
    check("aonly_c2_en_n", mux_en_n, 1);
    tick();
    check("aonly_c3_out_valid", out_valid, 0);

    // Reset in DRIVE: last is A now, reset must restore last=B
    a_valid = 1'b1; a_data = 4'b0111;
    tick(); a_valid = 1'b0;
    check("rdrv_en_n_pre", mux_en_n, 0);
    rst = 1'b1;
    tick();
    check("rdrv_out_valid", out_valid, 0);
    check("rdrv_en_n", mux_en_n, 1);
    check("rdrv_mux_a", mux_a, 0);
    check("rdrv_mux_b", mux_b, 0);
    check("rdrv_out_data", out_data, 0);
    rst = 1'b0;

    // Tie: A=1010, B=1101 continuously; expect A, B, A one every 3 cycles
    a_valid = 1'b1; b_valid = 1'b1; a_data = 4'b1010; b_data = 4'b1101;
    #1;
    check("tie0_a_ready", a_ready, 1);
    check("tie0_b_ready", b_ready, 0);
    tick();
    check("tie0_mux_b_kept", mux_b, 0);
    check("tie0_drive_ready", {a_ready, b_ready}, 0);
    tick();
    check("tie0_out_valid", out_valid, 1);
    check("tie0_out_data", out_data, 4'b1010);
    tick();
    check("tie1_a_ready", a_ready, 0);
    check("tie1_b_ready", b_ready, 1);
    tick();
    check("tie1_sel", mux_sel, 1);
    check("tie1_mux_a_kept", mux_a, 4'b1010);
    tick();
    check("tie1_out_data", out_data, 4'b1101);
    tick();
    check("tie2_a_ready", a_ready, 1);
    tick(); tick();
    check("tie2_out_data", out_data, 4'b1010);
    check("tie2_err", err, 0);
    a_valid = 1'b0; b_valid = 1'b0;
    tick();

    // Backpressure: A-only 0110, out_ready low for 5 cycles in HOLD
    out_ready = 1'b0; a_valid = 1'b1; a_data = 4'b0110;
    tick(); a_valid = 1'b0;
    tick();
    a_valid = 1'b1; b_valid = 1'b1; #1;
    for (int i = 0; i < 5; i++) begin
      check("bp_out_valid", out_valid, 1);
      check("bp_out_data", out_data, 4'b0110);
      check("bp_ready", {a_ready, b_ready}, 0);
      check("bp_en_n", mux_en_n, 1);
      tick();
    end
    // Handshake cycle; no grant even though both sources are valid
    out_ready = 1'b1; a_valid = 1'b0; b_valid = 1'b1; b_data = 4'b1101; fault = 1'b1;
    #1;
    check("bp_hs_b_ready", b_ready, 0);
    tick();
    check("bp_released", out_valid, 0);

    // Fault injection: B=1101 driven but mux returns 0000
    check("flt_b_ready", b_ready, 1);
    tick(); b_valid = 1'b0;
    check("flt_n1_err", err, 0);
    tick(); fault = 1'b0;
    check("flt_n2_err", err, 1);
    check("flt_n2_out_data", out_data, 4'b0000);
    tick();
    a_valid = 1'b1; a_data = 4'b0011;
    tick(); a_valid = 1'b0;
    tick(); tick();
    check("flt_sticky_err", err, 1);
    rst = 1'b1; tick(); rst = 1'b0;
    check("flt_rst_clears_err", err, 0);

`ifdef MUX2_RR_CTRL_GRANT_CNT_EN
    for (int t = 0; t < 300; t++) begin
      a_valid = 1'b1; a_data = t[3:0];
      tick(); a_valid = 1'b0;
      tick(); tick();
    end
    check("cnt_a_sat", cnt_a, 255);
    check("cnt_b_zero", cnt_b, 0);
    rst = 1'b1; tick(); rst = 1'b0;
    check("cnt_a_rst", cnt_a, 0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

// File: doc/mux2_rr_ctrl.md
# mux2_rr_ctrl

Round-robin controller wrapped around the 2:1 4-bit multiplexer with active-low enable. It accepts words from two valid/ready sources and presents the chosen word on the mux A or B input. It drives the mux select and active-low enable, captures the mux output `y` one cycle later, and offers it downstream on a valid/ready port. It also checks that the mux returned the expected word.

## Interface
- `WIDTH`, default 4: data width of sources, mux ports and output.
- `clk` input, 1 bit: single clock; all state updates on rising edge.
- `rst` input, 1 bit: synchronous, active-high reset.
- `a_valid` input, 1 bit: source A has a word.
- `a_data` input, WIDTH bits: source A word.
- `a_ready` output, 1 bit: source A word accepted this cycle.
- `b_valid` input, 1 bit: source B has a word.
- `b_data` input, WIDTH bits: source B word.
- `b_ready` output, 1 bit: source B word accepted this cycle.
- `mux_a` output, WIDTH bits: registered word to mux input A.
- `mux_b` output, WIDTH bits: registered word to mux input B.
- `mux_sel` output, 1 bit: 0 selects A, 1 selects B.
- `mux_en_n` output, 1 bit: active-low mux enable.
- `mux_y` input, WIDTH bits: mux output, fed back.
- `out_valid` output, 1 bit: captured word available.
- `out_data` output, WIDTH bits: captured word.
- `out_ready` input, 1 bit: downstream accepts.
- `err` output, 1 bit: sticky mismatch flag.

## Operation
- The FSM has three states: IDLE, DRIVE, HOLD.
- **IDLE**
  - `a_ready` and `b_ready` are combinational.
  - With a single requester, that requester is granted.
  - With both requesting, the source not granted last wins (round-robin pointer `last`).
  - On grant: the source's data loads into `mux_a` (A) or `mux_b` (B), `mux_sel` is set, `last` is updated, and the FSM moves to DRIVE.
  - The non-granted source's holding register is unchanged.
- **DRIVE** (exactly one cycle)
  - `mux_en_n`=0.
  - At the clock edge, `mux_y` is captured into `out_data`, `out_valid` is set, and the FSM moves to HOLD.
  - If `mux_y` ≠ the selected holding register, `err` is set and stays set until `rst`.
- **HOLD**
  - `mux_en_n`=1.
  - `out_valid`=1 and `out_data` are stable until `out_ready`.
  - On `out_valid && out_ready`: `out_valid` clears and the FSM returns to IDLE.
  - No grant occurs in the handshake cycle.
- Ready is never asserted outside IDLE. Source data does not need to be held after its ready cycle.

## Timing
- Reset values:
  - State: IDLE.
  - `mux_a`, `mux_b`, `out_data`: 0.
  - `mux_sel`, `out_valid`, `err`: 0.
  - `mux_en_n`: 1.
  - `last`: B, so A wins the first tie.
  - `a_ready`/`b_ready`: 0 while `rst` is high.
- Latency: grant at cycle N, enable low at N+1, `out_valid` at N+2.
- Throughput: one word per 3 cycles with `out_ready` held high.
- `out_ready` low in HOLD: the FSM stalls indefinitely with no grants and outputs unchanged.
- Reset mid-transaction: the in-flight word is dropped and every register returns to its reset value on the next edge.
- A valid deasserted before ready is not an error; no grant occurs.

## Configuration
- `MUX2_RR_CTRL_GRANT_CNT_EN` defined:
  - Adds outputs `cnt_a` and `cnt_b` (8 bits each).
  - Each is a saturating count of grants to its source, saturating at 255.
  - Both are cleared by `rst`.
- Undefined: the ports and counters do not exist, and the rest of the behaviour is identical.

## Structure
- Shared package holds:
  - State encodings: IDLE=2'd0, DRIVE=2'd1, HOLD=2'd2.
  - Select constants: SEL_A=0, SEL_B=1.
  - Default WIDTH.
- One natural sub-module: `rr_arb2`, a two-requester round-robin arbiter. It takes req[1:0] and `last`, and returns a one-hot grant.
- The mux itself stays outside this block.

## Test plan
- A-only request:
  - Stimulus: `a_valid`=1, `a_data`=1010, mux model behaves correctly.
  - Response: `a_ready` in cycle 0; `mux_sel`=0 and `mux_en_n`=0 in cycle 1; `out_valid` with `out_data`=1010 in cycle 2; `err`=0.
- Tie:
  - Stimulus: A=1010 and B=1101 both valid continuously, `out_ready`=1.
  - Response: grants alternate A, B, A. Outputs are 1010, 1101, 1010, one every 3 cycles.
- Backpressure:
  - Stimulus: `out_ready`=0 for 5 cycles after `out_valid`.
  - Response: `out_data` is stable, no ready is asserted, and `mux_en_n`=1 throughout.
- Fault injection:
  - Stimulus: the mux model forces `mux_y`=0000 while B=1101 is driven.
  - Response: `err`=1 from cycle N+2 and stays set until `rst`.
- Reset in DRIVE:
  - Stimulus: assert `rst` during DRIVE.
  - Response: next cycle has `out_valid`=0, `mux_en_n`=1, all data registers 0. The next tie goes to A.
- Counters (macro on):
  - Stimulus: 300 A-only transactions.
  - Response: `cnt_a`=255, `cnt_b`=0.
